nervous_stream_sequencer: RTL and testbench

Front-end controller for the nervous-shock detection path. Accepts parallel sample words from the acquisition side over a valid/ready handshake. Serializes each word MSB-first onto the detector's single-bit data input and samples the detector's 2-bit abnormality code on every shifted bit. After each word it issues a one-cycle summary (highest severity, event count) and raises a sticky alarm on a critical event until acknowledged.

---
 rtl/nervous_stream_sequencer.sv | 133 +++++++++++++
 tb/tb_nervous_stream_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/nervous_stream_sequencer.sv
// Serializes sample words MSB-first to the nervous-shock detector and summarizes its per-bit codes.
// Optional `NERVOUS_SEQ_BACK_TO_BACK_EN lets REPORT accept the next word directly (period WORD_W+1).
module nervous_stream_sequencer #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] wordIn,
    input  logic              wordValid,
    output logic              wordReady,
    output logic              detBit,
    input  logic [1:0]        detAbnormality,
    output logic              summaryValid,
    output logic [1:0]        summaryCode,
    output logic [CNT_W-1:0]  eventCount,
    output logic              alarm,
    input  logic              alarmAck
);

    localparam int                IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  shiftReg_q, shiftReg_d;
    logic [IDX_W-1:0]   bitIdx_q, bitIdx_d;
    logic [1:0]         accSev_q, accSev_d;
    logic [CNT_W-1:0]   accCnt_q, accCnt_d;
    logic [1:0]         sumCode_q, sumCode_d;
    logic [CNT_W-1:0]   sumCnt_q, sumCnt_d;
    logic               alarm_q, alarm_d;

    logic               loadWord;
    logic               alarmSet;
    logic [1:0]         sevNext;
    logic [CNT_W-1:0]   cntNext;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitIdx_q   <= '0;
            accSev_q   <= '0;
            accCnt_q   <= '0;
            sumCode_q  <= '0;
            sumCnt_q   <= '0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bitIdx_q   <= bitIdx_d;
            accSev_q   <= accSev_d;
            accCnt_q   <= accCnt_d;
            sumCode_q  <= sumCode_d;
            sumCnt_q   <= sumCnt_d;
            alarm_q    <= alarm_d;
        end
    end

    // Numeric order of the 2-bit code equals severity order, so max is a plain compare.
    always_comb begin
        sevNext = (detAbnormality > accSev_q) ? detAbnormality : accSev_q;
        cntNext = ((detAbnormality != 2'b00) && (accCnt_q != CNT_MAX)) ? accCnt_q + 1'b1 : accCnt_q;
    end

    always_comb begin
        state_d      = state_q;
        shiftReg_d   = shiftReg_q;
        bitIdx_d     = bitIdx_q;
        accSev_d     = accSev_q;
        accCnt_d     = accCnt_q;
        sumCode_d    = sumCode_q;
        sumCnt_d     = sumCnt_q;
        loadWord     = 1'b0;
        alarmSet     = 1'b0;
        wordReady    = 1'b0;
        detBit       = 1'b0;
        summaryValid = 1'b0;

        case (state_q)
            IDLE: begin
                wordReady = 1'b1;
                loadWord  = wordValid;
            end
            SHIFT: begin
                detBit     = shiftReg_q[WORD_W-1];
                shiftReg_d = shiftReg_q << 1;
                bitIdx_d   = bitIdx_q + 1'b1;
                accSev_d   = sevNext;
                accCnt_d   = cntNext;
                // Summary includes the final bit's code so it is valid on entry to REPORT.
                if (bitIdx_q == LAST_IDX) begin
                    state_d   = REPORT;
                    sumCode_d = sevNext;
                    sumCnt_d  = cntNext;
                    alarmSet  = (sevNext == 2'b11);
                end
            end
            REPORT: begin
                summaryValid = 1'b1;
                alarmSet     = (sumCode_q == 2'b11);
                state_d      = IDLE;
`ifdef NERVOUS_SEQ_BACK_TO_BACK_EN
                wordReady    = 1'b1;
                loadWord     = wordValid;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (loadWord) begin
            state_d    = SHIFT;
            shiftReg_d = wordIn;
            bitIdx_d   = '0;
            accSev_d   = '0;
            accCnt_d   = '0;
        end

        alarm_d = alarmSet | (alarm_q & ~alarmAck);
    end

    assign summaryCode = sumCode_q;
    assign eventCount  = sumCnt_q;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_nervous_stream_sequencer.sv
// Directed bench: table of words with per-bit detector stubs, plus alarm, reset and back-to-back sequences.
module tb_nervous_stream_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] wordIn;
    logic        wordValid;
    logic        alarmAck;
    logic [1:0]  detAbnormality;

    logic        wordReady, detBit, summaryValid, alarm;
    logic [1:0]  summaryCode;
    logic [7:0]  eventCount;

    logic        satReady, satDetBit, satSummaryValid, satAlarm;
    logic [1:0]  satCode;
    logic [1:0]  satCount;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    nervous_stream_sequencer #(.WORD_W(16), .CNT_W(8)) dut (
        .clock(clock), .reset_n(reset_n), .wordIn(wordIn), .wordValid(wordValid),
        .wordReady(wordReady), .detBit(detBit), .detAbnormality(detAbnormality),
        .summaryValid(summaryValid), .summaryCode(summaryCode), .eventCount(eventCount),
        .alarm(alarm), .alarmAck(alarmAck)
    );

    nervous_stream_sequencer #(.WORD_W(16), .CNT_W(2)) dutSat (
        .clock(clock), .reset_n(reset_n), .wordIn(wordIn), .wordValid(wordValid),
        .wordReady(satReady), .detBit(satDetBit), .detAbnormality(detAbnormality),
        .summaryValid(satSummaryValid), .summaryCode(satCode), .eventCount(satCount),
        .alarm(satAlarm), .alarmAck(alarmAck)
    );

    typedef struct {
        logic [15:0] word;
        logic [31:0] stub;
        logic [1:0]  expCode;
        logic [7:0]  expCount;
        logic [1:0]  expSat;
        logic        expAlarm;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Presents a word in IDLE, then walks the 16 shift cycles; returns at the REPORT-cycle negedge.
    task automatic applyStimulus(input logic [15:0] w, input logic [31:0] stub);
        @(negedge clock);
        wordIn         = w;
        wordValid      = 1'b1;
        detAbnormality = 2'b11;
        checkOutput("readyIdle", {31'b0, wordReady}, 32'd1);
        @(negedge clock);
        wordValid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            detAbnormality = stub[2*i +: 2];
            checkOutput($sformatf("detBit[%0d]", i), {31'b0, detBit}, {31'b0, w[15-i]});
            if (i == 0) begin
                checkOutput("readyShift", {31'b0, wordReady}, 32'd0);
                checkOutput("noSumInShift", {31'b0, summaryValid}, 32'd0);
            end
            @(negedge clock);
        end
        detAbnormality = 2'b11;
    endtask

    initial begin
        int     pulses;
        int     accepts;
        int     firstPulse;
        int     secondPulse;
        logic   sawSum;
        logic   detZeroAtReport;

        vecs[0] = '{16'hA5A5, 32'h0000_0000, 2'b00, 8'd0,  2'd0, 1'b0};
        vecs[1] = '{16'h1234, 32'h0008_8040, 2'b10, 8'd3,  2'd3, 1'b0};
        vecs[2] = '{16'hFFFF, 32'hC000_0000, 2'b11, 8'd1,  2'd1, 1'b1};
        vecs[3] = '{16'h0F0F, 32'h5555_5555, 2'b01, 8'd16, 2'd3, 1'b0};
        vecs[4] = '{16'h8001, 32'h0001_0003, 2'b11, 8'd2,  2'd2, 1'b1};
        vecs[5] = '{16'h5A3C, 32'h0000_0420, 2'b10, 8'd2,  2'd2, 1'b0};

        reset_n        = 1'b0;
        wordIn         = '0;
        wordValid      = 1'b0;
        alarmAck       = 1'b0;
        detAbnormality = 2'b00;
        #1;
        checkOutput("rstReady", {31'b0, wordReady}, 32'd1);
        checkOutput("rstDetBit", {31'b0, detBit}, 32'd0);
        checkOutput("rstSumValid", {31'b0, summaryValid}, 32'd0);
        checkOutput("rstCode", {30'b0, summaryCode}, 32'd0);
        checkOutput("rstCount", {24'b0, eventCount}, 32'd0);
        checkOutput("rstAlarm", {31'b0, alarm}, 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].word, vecs[v].stub);
            checkOutput($sformatf("v%0d sumValid", v), {31'b0, summaryValid}, 32'd1);
            checkOutput($sformatf("v%0d detBitRep", v), {31'b0, detBit}, 32'd0);
            checkOutput($sformatf("v%0d code", v), {30'b0, summaryCode}, {30'b0, vecs[v].expCode});
            checkOutput($sformatf("v%0d count", v), {24'b0, eventCount}, {24'b0, vecs[v].expCount});
            checkOutput($sformatf("v%0d satCount", v), {30'b0, satCount}, {30'b0, vecs[v].expSat});
            checkOutput($sformatf("v%0d satCode", v), {30'b0, satCode}, {30'b0, vecs[v].expCode});
            checkOutput($sformatf("v%0d alarm", v), {31'b0, alarm}, {31'b0, vecs[v].expAlarm});
            @(negedge clock);
            detAbnormality = 2'b00;
            checkOutput($sformatf("v%0d pulseEnd", v), {31'b0, summaryValid}, 32'd0);
            checkOutput($sformatf("v%0d readyAfter", v), {31'b0, wordReady}, 32'd1);
            checkOutput($sformatf("v%0d codeHeld", v), {30'b0, summaryCode}, {30'b0, vecs[v].expCode});
            if (vecs[v].expAlarm) begin
                repeat (3) @(negedge clock);
                checkOutput($sformatf("v%0d alarmSticky", v), {31'b0, alarm}, 32'd1);
                alarmAck = 1'b1;
                @(negedge clock);
                alarmAck = 1'b0;
                checkOutput($sformatf("v%0d alarmCleared", v), {31'b0, alarm}, 32'd0);
            end
        end

        // Second critical report coincides with alarmAck: the set must win.
        applyStimulus(16'h0F0F, 32'hC000_0000);
        checkOutput("firstCritAlarm", {31'b0, alarm}, 32'd1);
        @(negedge clock);
        applyStimulus(16'hF0F0, 32'h0000_0003);
        alarmAck = 1'b1;
        checkOutput("secondCritCode", {30'b0, summaryCode}, 32'd3);
        @(negedge clock);
        alarmAck       = 1'b0;
        detAbnormality = 2'b00;
        checkOutput("setWinsAlarm", {31'b0, alarm}, 32'd1);

        // Reset mid-SHIFT with alarm and summary loaded: immediate asynchronous clear.
        @(negedge clock);
        wordIn    = 16'hFFFF;
        wordValid = 1'b1;
        @(negedge clock);
        wordValid = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("preRstDetBit", {31'b0, detBit}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("midRstReady", {31'b0, wordReady}, 32'd1);
        checkOutput("midRstDetBit", {31'b0, detBit}, 32'd0);
        checkOutput("midRstCode", {30'b0, summaryCode}, 32'd0);
        checkOutput("midRstCount", {24'b0, eventCount}, 32'd0);
        checkOutput("midRstAlarm", {31'b0, alarm}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        sawSum  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (summaryValid) sawSum = 1'b1;
        end
        checkOutput("noSumAfterRst", {31'b0, sawSum}, 32'd0);
        checkOutput("readyAfterRst", {31'b0, wordReady}, 32'd1);
        alarmAck = 1'b1;
        @(negedge clock);
        alarmAck = 1'b0;
        checkOutput("ackNoAlarm", {31'b0, alarm}, 32'd0);

        // Two words with wordValid held: measure summary spacing.
        wordIn          = 16'hFFFF;
        wordValid       = 1'b1;
        pulses          = 0;
        accepts         = 0;
        firstPulse      = -1;
        secondPulse     = -1;
        detZeroAtReport = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (accepts >= 2) wordValid = 1'b0;
            if (summaryValid) begin
                if (pulses == 0) begin
                    firstPulse      = c;
                    detZeroAtReport = ~detBit;
                end else if (pulses == 1) begin
                    secondPulse = c;
                end
                pulses++;
            end
            if (wordValid && wordReady) accepts++;
            @(negedge clock);
        end
        wordValid = 1'b0;
        checkOutput("b2bPulses", pulses, 32'd2);
`ifdef NERVOUS_SEQ_BACK_TO_BACK_EN
        checkOutput("b2bGap", secondPulse - firstPulse, 32'd17);
`else
        checkOutput("b2bGap", secondPulse - firstPulse, 32'd18);
`endif
        checkOutput("b2bDetZeroReport", {31'b0, detZeroAtReport}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
